// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial writer.
//   state_t      : frame sequencing states
//   DEF_CLK_DIV  : default clk cycles per sclk half-period
//   DEF_CS_GAP   : default minimum cs_n-high cycles between frames
//   frame_w()    : total serial frame width (command + sample)
//   cnt_w()      : width of a counter that spans 0..n-1, never narrower than 1 bit
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_CS_GAP  = 2;

  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// Half-period counter for the serial clock.
// While en is high sclk starts high and toggles every CLK_DIV clk cycles;
// while en is low the counter is held cleared and sclk is low.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   run the divider (asserted only while shifting)
//   sclk       out  serial clock level
//   fall       out  last cycle of a high half (sclk falls next cycle)
//   period_end out  last cycle of a low half (bit period complete)
module sclk_divider
  import dac_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic fall,
  output logic period_end
);

  localparam int            CW        = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          low_half;
  logic          half_end;

  assign half_end = en && (cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt      <= '0;
      low_half <= 1'b0;
    end else if (half_end) begin
      cnt      <= '0;
      low_half <= ~low_half;
    end else begin
      cnt      <= cnt + CW'(1);
    end
  end

  assign sclk       = en & ~low_half;
  assign fall       = half_end & ~low_half;
  assign period_end = half_end & low_half;

endmodule

// File: rtl/dac_writer.sv
// Transmit side of the converter serial link. Accepts one sample plus a
// command nibble and frames {cmd, data} MSB-first on sclk/cs_n/sdo.
// Frame: LEAD (cs_n low, sclk low) -> SHIFT (FRAME_W bit periods, sclk
// high then low) -> TRAIL (sclk low, last bit held) -> GAP (cs_n high).
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   in_data   in   sample to send
//   in_cmd    in   command bits, sent first
//   in_valid  in   upstream has a word
//   in_ready  out  accepting a word (IDLE and out of reset)
//   sclk      out  serial clock, idles low
//   cs_n      out  frame select, active low
//   sdo       out  serial data, changes as sclk falls
//   busy      out  frame in progress
//   done      out  one-cycle pulse as cs_n returns high
//   ldac_n    out  only with DAC_WRITER_LDAC_EN: low for the GAP cycles of a
//                  completed frame to latch the DAC output
module dac_writer
  import dac_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CMD_W   = 4,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_GAP  = DEF_CS_GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sclk,
  output logic              cs_n,
  output logic              sdo,
  output logic              busy,
  output logic              done
`ifdef DAC_WRITER_LDAC_EN
  ,
  output logic              ldac_n
`endif
);

  localparam int            FRAME_W   = frame_w(CMD_W, DATA_W);
  localparam int            TW        = cnt_w((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
  localparam int            BW        = $clog2(FRAME_W + 1);
  localparam logic [TW-1:0] EDGE_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [TW-1:0]      tmr;
  logic [BW-1:0]      bit_cnt;
  logic [FRAME_W-1:0] frame_sr;
  logic               armed;
  logic               accept;
  logic               fall;
  logic               period_end;

  sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == SHIFT),
    .sclk      (sclk),
    .fall      (fall),
    .period_end(period_end)
  );

  // armed keeps in_ready low during reset and high from the first cycle after release
  assign accept = (state == IDLE) && armed && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      tmr     <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      // timer runs only inside the fixed-length phases and restarts on every transition
      if (state_nxt != state || state == IDLE || state == SHIFT) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + TW'(1);
      end
      if (state != SHIFT) begin
        bit_cnt <= '0;
      end else if (period_end && bit_cnt != BIT_LAST) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // The last bit is not shifted out so it stays on sdo through TRAIL
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_sr <= {in_cmd, in_data};
    end else if (fall && bit_cnt != BIT_LAST) begin
      frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    cs_n      = 1'b1;
    sdo       = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    in_ready  = (state == IDLE) && armed;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LEAD;
      end
      LEAD: begin
        cs_n = 1'b0;
        sdo  = frame_sr[FRAME_W-1];
        if (tmr == EDGE_LAST) state_nxt = SHIFT;
      end
      SHIFT: begin
        cs_n = 1'b0;
        sdo  = frame_sr[FRAME_W-1];
        if (period_end && bit_cnt == BIT_LAST) state_nxt = TRAIL;
      end
      TRAIL: begin
        cs_n = 1'b0;
        sdo  = frame_sr[FRAME_W-1];
        if (tmr == EDGE_LAST) state_nxt = GAP;
      end
      GAP: begin
        done = (tmr == '0);
        if (tmr == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DAC_WRITER_LDAC_EN
  // GAP is only reachable through a completed frame, so aborts never pulse ldac_n
  assign ldac_n = (state != GAP);
`endif

endmodule

// File: tb/tb_dac_writer.sv
module tb_dac_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        sel;
  logic [11:0] in_data;
  logic [3:0]  in_cmd;
  logic [1:0]  in_ready_w, sclk_w, cs_n_w, sdo_w, busy_w, done_w, ldac_w;

  int n_chk = 0;
  int n_bad = 0;

  // per-cycle record, bit 0 cs_n, 1 sclk, 2 sdo, 3 done, 4 in_ready, 5 busy, 6 ldac_n
  logic [6:0] rec [0:400];

  always #5 clk = ~clk;

  dac_writer #(.DATA_W(12), .CMD_W(4), .CLK_DIV(4), .CS_GAP(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cmd(in_cmd),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_w[0]), .sclk(sclk_w[0]),
    .cs_n(cs_n_w[0]), .sdo(sdo_w[0]), .busy(busy_w[0]), .done(done_w[0])
`ifdef DAC_WRITER_LDAC_EN
    , .ldac_n(ldac_w[0])
`endif
  );

  dac_writer #(.DATA_W(12), .CMD_W(4), .CLK_DIV(1), .CS_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cmd(in_cmd),
    .in_valid(in_valid & sel), .in_ready(in_ready_w[1]), .sclk(sclk_w[1]),
    .cs_n(cs_n_w[1]), .sdo(sdo_w[1]), .busy(busy_w[1]), .done(done_w[1])
`ifdef DAC_WRITER_LDAC_EN
    , .ldac_n(ldac_w[1])
`endif
  );

`ifndef DAC_WRITER_LDAC_EN
  assign ldac_w = 2'b11;
`endif

  function automatic logic [6:0] cur();
    int i;
    i = sel ? 1 : 0;
    return {ldac_w[i], busy_w[i], in_ready_w[i], done_w[i], sdo_w[i], sclk_w[i], cs_n_w[i]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt(input int b, input logic v, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (rec[c][b] == v) n++;
    return n;
  endfunction

  function automatic int first(input int b, input logic v, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) if (rec[c][b] == v) return c;
    return 0;
  endfunction

  function automatic int rises(input int hi);
    int n = 0;
    for (int c = 1; c <= hi; c++) if (rec[c][1] && !rec[c-1][1]) n++;
    return n;
  endfunction

  function automatic logic [15:0] word(input int k, input int hi);
    int nr = 0;
    logic [15:0] w = '0;
    for (int c = 1; c <= hi; c++) begin
      if (rec[c][1] && !rec[c-1][1]) begin
        if (nr / 16 == k) w = {w[14:0], rec[c][2]};
        nr++;
      end
    end
    return w;
  endfunction

  // Presents a word, waits (bounded) for in_ready, returns just after the handshake edge
  task automatic send(input logic [3:0] c, input logic [11:0] d, input bit keep);
    int w;
    logic [6:0] r;
    @(negedge clk);
    in_cmd = c;
    in_data = d;
    in_valid = 1'b1;
    w = 0;
    r = cur();
    while (!r[4] && w < 300) begin
      @(negedge clk);
      r = cur();
      w++;
    end
    check_eq("accept_wait", (w < 300), 1);
    rec[0] = r;
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic observe(input int n, input int pulse_at, input int rst_at);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      rec[c] = cur();
      if (pulse_at != 0) in_valid = (c == pulse_at);
      if (rst_at != 0 && c == rst_at) rst_n = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) rst_n = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] r;
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_data = '0; in_cmd = '0;
    repeat (3) @(negedge clk);
    r = cur();
    check_eq("rst_cs_n", r[0], 1);
    check_eq("rst_sclk", r[1], 0);
    check_eq("rst_sdo", r[2], 0);
    check_eq("rst_done", r[3], 0);
    check_eq("rst_ready", r[4], 0);
    check_eq("rst_busy", r[5], 0);
    check_eq("rst_ldac", r[6], 1);
    rst_n = 1'b1;
    @(negedge clk);
    r = cur();
    check_eq("ready_after_rst", r[4], 1);

    // single frame 3/A5C
    send(4'h3, 12'hA5C, 0);
    observe(145, 0, 0);
    check_eq("t1_word", word(0, 145), 16'h3A5C);
    check_eq("t1_rises", rises(145), 16);
    check_eq("t1_cs_first", first(0, 0, 1, 145), 1);
    check_eq("t1_cs_lowcnt", cnt(0, 0, 1, 145), 136);
    check_eq("t1_cs_136", rec[136][0], 0);
    check_eq("t1_cs_137", rec[137][0], 1);
    check_eq("t1_done_at", first(3, 1, 1, 145), 137);
    check_eq("t1_done_cnt", cnt(3, 1, 1, 145), 1);
    check_eq("t1_ready_at", first(4, 1, 1, 145), 139);
    check_eq("t1_busy_1", rec[1][5], 1);
    check_eq("t1_sdo_lead", rec[1][2], 0);
    check_eq("t1_sdo_gap", rec[137][2], 0);
`ifdef DAC_WRITER_LDAC_EN
    check_eq("t1_ldac_at", first(6, 0, 1, 145), 137);
    check_eq("t1_ldac_cnt", cnt(6, 0, 1, 145), 2);
`endif

    // back-to-back with in_valid held
    send(4'h5, 12'h000, 1);
    in_cmd = 4'hA;
    in_data = 12'hFFF;
    observe(277, 0, 0);
    in_valid = 1'b0;
    check_eq("t2_word0", word(0, 277), 16'h5000);
    check_eq("t2_word1", word(1, 277), 16'hAFFF);
    check_eq("t2_rises", rises(277), 32);
    check_eq("t2_gap_high", cnt(0, 1, 137, 139), 3);
    check_eq("t2_cs2_first", first(0, 0, 137, 277), 140);
    check_eq("t2_ready_cnt", cnt(4, 1, 1, 277), 1);
    check_eq("t2_ready_at", first(4, 1, 1, 277), 139);

    // in_valid pulse during SHIFT is ignored
    send(4'h6, 12'h0F0, 0);
    observe(150, 60, 0);
    check_eq("t3_word", word(0, 150), 16'h60F0);
    check_eq("t3_cs_lowcnt", cnt(0, 0, 1, 150), 136);
    check_eq("t3_ready_at", first(4, 1, 1, 150), 139);
    check_eq("t3_rises", rises(150), 16);

    // reset mid-frame
    send(4'h7, 12'h777, 0);
    observe(60, 0, 50);
    check_eq("t4_cs_50", rec[50][0], 0);
    check_eq("t4_cs_51", rec[51][0], 1);
    check_eq("t4_sclk_51", rec[51][1], 0);
    check_eq("t4_sdo_51", rec[51][2], 0);
    check_eq("t4_ready_51", rec[51][4], 0);
    check_eq("t4_ready_52", rec[52][4], 1);
    check_eq("t4_done_cnt", cnt(3, 1, 1, 60), 0);
    check_eq("t4_ldac_cnt", cnt(6, 0, 1, 60), 0);
    send(4'hC, 12'h123, 0);
    observe(145, 0, 0);
    check_eq("t4_word", word(0, 145), 16'hC123);
    check_eq("t4_done_at", first(3, 1, 1, 145), 137);

    // CLK_DIV=1, CS_GAP=1 instance
    sel = 1'b1;
    send(4'h9, 12'h5A3, 0);
    observe(40, 0, 0);
    check_eq("t5_word", word(0, 40), 16'h95A3);
    check_eq("t5_rises", rises(40), 16);
    check_eq("t5_cs_lowcnt", cnt(0, 0, 1, 40), 34);
    check_eq("t5_cs_35", rec[35][0], 1);
    check_eq("t5_sclk_2", rec[2][1], 1);
    check_eq("t5_sclk_3", rec[3][1], 0);
    check_eq("t5_done_at", first(3, 1, 1, 40), 35);
    check_eq("t5_ready_at", first(4, 1, 1, 40), 36);
`ifdef DAC_WRITER_LDAC_EN
    check_eq("t5_ldac_cnt", cnt(6, 0, 1, 40), 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
